// File: rtl/apb_uart_tx_s_if.sv
// apb_uart_tx_s_if: APB slave bus bundle for the UART transmitter
interface apb_uart_tx_s_if #(parameter int BUS_WIDTH = 16);
  logic [BUS_WIDTH-1:0] S_PADDR;
  logic                 S_PWRITE;
  logic                 S_PSELx;
  logic                 S_PENABLE;
  logic [BUS_WIDTH-1:0] S_PWDATA;
  logic [BUS_WIDTH-1:0] S_PRDATA;
  logic                 S_PREADY;
  modport master (output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, input S_PRDATA, S_PREADY);
  modport slave (input S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, output S_PRDATA, S_PREADY);
endinterface

// File: rtl/apb_uart_tx_s.sv
// apb_uart_tx_s: APB slave 8N1 UART transmitter with TX FIFO and STATUS register
// Optional drained-transmitter pulse tx_irq is enabled by defining VMICRO16_UART_TX_IRQ_EN.
module apb_uart_tx_s #(
  parameter int BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           reset,
  apb_uart_tx_s_if.slave s_apb,
  output logic           uart_tx
`ifdef VMICRO16_UART_TX_IRQ_EN
  ,
  output logic           tx_irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         r_state;
  logic [7:0]     r_fifo [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic [BW-1:0]  r_baud_cnt;
  logic           r_tx;

  logic w_acc, w_is_data, w_full, w_empty, w_ready, w_push, w_bit_end, w_pop, w_unused;
  logic [BUS_WIDTH-1:0] w_status;

  assign w_acc     = s_apb.S_PSELx & s_apb.S_PENABLE;
  assign w_is_data = !s_apb.S_PADDR[0];
  assign w_full    = r_count == CW'(FIFO_DEPTH);
  assign w_empty   = r_count == '0;
  // a DATA write into a full FIFO stretches the transfer; reset aborts any access
  assign w_ready   = w_acc & !reset & !(s_apb.S_PWRITE & w_is_data & w_full);
  assign w_push    = w_ready & s_apb.S_PWRITE & w_is_data;
  assign w_bit_end = r_baud_cnt == '0;
  assign w_pop     = !w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));
  assign w_unused  = ^{s_apb.S_PADDR[BUS_WIDTH-1:1], s_apb.S_PWDATA[BUS_WIDTH-1:8]};

  always_comb begin
    w_status           = '0;
    w_status[0]        = w_full;
    w_status[1]        = w_empty;
    w_status[2]        = r_state != IDLE;
    w_status[8 +: CW]  = r_count;
  end

  // read data must be zero outside a completing STATUS read: the bus ORs slave outputs
  assign s_apb.S_PRDATA = (w_ready & !s_apb.S_PWRITE & s_apb.S_PADDR[0]) ? w_status : '0;
  assign s_apb.S_PREADY = w_ready;
  assign uart_tx        = r_tx;

  always_ff @(posedge clk)
    if (w_push) r_fifo[r_wr_ptr] <= s_apb.S_PWDATA[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (!w_empty) begin
          r_shift    <= r_fifo[r_rd_ptr];
          r_bit_cnt  <= '0;
          r_baud_cnt <= BAUD_MAX;
          r_tx       <= 1'b0;
          r_state    <= START;
        end
        START: if (w_bit_end) begin
          r_baud_cnt <= BAUD_MAX;
          r_tx       <= r_shift[0];
          r_state    <= DATA;
        end else r_baud_cnt <= r_baud_cnt - 1'b1;
        DATA: if (w_bit_end) begin
          r_baud_cnt <= BAUD_MAX;
          r_shift    <= r_shift >> 1;
          r_bit_cnt  <= r_bit_cnt + 1'b1;
          r_tx       <= (r_bit_cnt == 3'd7) ? 1'b1 : r_shift[1];
          r_state    <= (r_bit_cnt == 3'd7) ? STOP : DATA;
        end else r_baud_cnt <= r_baud_cnt - 1'b1;
        STOP: if (w_bit_end && !w_empty) begin
          r_shift    <= r_fifo[r_rd_ptr];
          r_bit_cnt  <= '0;
          r_baud_cnt <= BAUD_MAX;
          r_tx       <= 1'b0;
          r_state    <= START;
        end else if (w_bit_end) begin
          r_tx       <= 1'b1;
          r_state    <= IDLE;
        end else r_baud_cnt <= r_baud_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VMICRO16_UART_TX_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk)
    r_irq <= !reset & (r_state == STOP) & w_bit_end & w_empty;
  assign tx_irq = r_irq;
`endif
endmodule

// File: tb/tb_apb_uart_tx_s.sv
// tb_apb_uart_tx_s: directed self-checking bench for the APB UART transmitter
module tb_apb_uart_tx_s;
  localparam int BW = 16;
  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_tx;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  apb_uart_tx_s_if #(.BUS_WIDTH(BW)) bus ();

`ifdef VMICRO16_UART_TX_IRQ_EN
  logic tx_irq;
  int   irq_rises = 0;
  int   irq_hi = 0;
  int   irq_last_cyc = 0;
  logic irq_prev = 1'b0;
  always @(negedge clk) begin
    if (tx_irq) irq_hi++;
    if (tx_irq && !irq_prev) begin
      irq_rises++;
      irq_last_cyc = cyc;
    end
    irq_prev = tx_irq;
  end
`endif

  apb_uart_tx_s #(.BUS_WIDTH(BW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_apb   (bus),
    .uart_tx (uart_tx)
`ifdef VMICRO16_UART_TX_IRQ_EN
    ,
    .tx_irq  (tx_irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // call just after a clock edge; returns just after the completing edge
  task automatic apb(input logic [15:0] addr, input logic wr, input logic [15:0] data,
                     output logic [15:0] rdata, output int waits, output int edge_cyc);
    waits = 0;
    rdata = '0;
    edge_cyc = -1;
    bus.S_PSELx = 1'b1;
    bus.S_PENABLE = 1'b0;
    bus.S_PADDR = addr;
    bus.S_PWRITE = wr;
    bus.S_PWDATA = data;
    sync();
    bus.S_PENABLE = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.S_PREADY) begin
        rdata = bus.S_PRDATA;
        sync();
        edge_cyc = cyc;
        break;
      end
      waits++;
    end
    bus.S_PSELx = 1'b0;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE = 1'b0;
    if (edge_cyc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL apb_timeout: addr 0x%0h never got PREADY, required within 200 cycles", addr);
    end
  endtask

  function automatic logic [39:0] exp_wave(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] w;
    bits = {1'b1, b, 1'b0};
    for (int c = 0; c < FRAME; c++) w[c] = bits[c / CPB];
    return w;
  endfunction

  // starts just after the edge that begins the start bit
  task automatic capture_frame(output logic [39:0] w);
    for (int c = 0; c < FRAME; c++) begin
      w[c] = uart_tx;
      sync();
    end
  endtask

  initial begin
    vec_t        vecs[6];
    logic [15:0] rd;
    logic [39:0] wave;
    logic [39:0] frames[10];
    int          waits[11];
    int          w, e, e1, e10;
    logic        saw_low;

    vecs[0] = '{16'h00B1, 1'b0, 16'h0000, 16'h0002};
    vecs[1] = '{16'h00B0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{16'h00B1, 1'b1, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h00B1, 1'b0, 16'h0000, 16'h0002};
    vecs[4] = '{16'h00B3, 1'b0, 16'h0000, 16'h0002};
    vecs[5] = '{16'hFFFE, 1'b0, 16'h0000, 16'h0000};

    bus.S_PSELx = 1'b0;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE = 1'b0;
    bus.S_PADDR = '0;
    bus.S_PWDATA = '0;

    repeat (2) sync();
    check("reset_uart_tx", uart_tx, 1);
    check("reset_pready", bus.S_PREADY, 0);
    check("reset_prdata", bus.S_PRDATA, 0);
`ifdef VMICRO16_UART_TX_IRQ_EN
    check("reset_tx_irq", tx_irq, 0);
`endif
    reset = 1'b0;
    sync();

    for (int i = 0; i < 6; i++) begin
      apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, w, e);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_waits", i), w, 0);
    end

    apb(16'h00B0, 1'b1, 16'h0055, rd, w, e);
    check("single_idle_at_E", uart_tx, 1);
    sync();
    capture_frame(wave);
    check("single_frame_55", wave, exp_wave(8'h55));
    check("single_idle_E41", uart_tx, 1);
    apb(16'h00B1, 1'b0, 16'h0000, rd, w, e);
    check("single_status_after", rd, 16'h0002);

    apb(16'h00B0, 1'b1, 16'h00A1, rd, w, e1);
    apb(16'h00B0, 1'b1, 16'h00B2, rd, w, e);
    apb(16'h00B0, 1'b1, 16'h00C3, rd, w, e);
    apb(16'h00B1, 1'b0, 16'h0000, rd, w, e);
    check("mid_status", rd, 16'h0204);
    apb(16'h00B1, 1'b1, 16'hFFFF, rd, w, e);
    apb(16'h00B1, 1'b0, 16'h0000, rd, w, e);
    check("mid_status_after_wr", rd, 16'h0204);
    bus.S_PSELx = 1'b0;
    bus.S_PENABLE = 1'b1;
    bus.S_PADDR = 16'h00B1;
    #2;
    check("nosel_prdata", bus.S_PRDATA, 0);
    check("nosel_pready", bus.S_PREADY, 0);
    sync();
    // reset during a DATA bit of 0xA1 that is low, with a DATA write in its access phase
    check("pre_reset_tx_low", uart_tx, 0);
    reset = 1'b1;
    bus.S_PSELx = 1'b1;
    bus.S_PENABLE = 1'b1;
    bus.S_PWRITE = 1'b1;
    bus.S_PADDR = 16'h00B0;
    bus.S_PWDATA = 16'h0077;
    sync();
    check("rst_mid_tx", uart_tx, 1);
    reset = 1'b0;
    bus.S_PSELx = 1'b0;
    bus.S_PENABLE = 1'b0;
    bus.S_PWRITE = 1'b0;
    apb(16'h00B1, 1'b0, 16'h0000, rd, w, e);
    check("rst_mid_status", rd, 16'h0002);
    saw_low = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (!uart_tx) saw_low = 1'b1;
      sync();
    end
    check("rst_no_frames", saw_low, 0);

    apb(16'h00B0, 1'b1, 16'h0001, rd, w, e1);
    fork
      begin
        for (int k = 2; k <= 10; k++) apb(16'h00B0, 1'b1, 16'(k), rd, waits[k], e10);
      end
      begin
        sync();
        for (int f = 0; f < 10; f++) capture_frame(frames[f]);
      end
    join
    for (int k = 2; k <= 9; k++) check($sformatf("bp_waits_wr%0d", k), waits[k], 0);
    check("bp_wr10_stalled", waits[10] > 0, 1);
    check("bp_wr10_edge", e10 - e1, 1 + FRAME + 1);
    for (int f = 0; f < 10; f++) check($sformatf("bp_frame%0d", f + 1), frames[f], exp_wave(8'(f + 1)));
    check("bp_idle_after", uart_tx, 1);
    apb(16'h00B1, 1'b0, 16'h0000, rd, w, e);
    check("bp_status_after", rd, 16'h0002);

`ifdef VMICRO16_UART_TX_IRQ_EN
    begin
      int rises0, hi0;
      rises0 = irq_rises;
      hi0 = irq_hi;
      apb(16'h00B0, 1'b1, 16'h005A, rd, w, e1);
      apb(16'h00B0, 1'b1, 16'h00A5, rd, w, e);
      repeat (2 * FRAME + 10) sync();
      check("irq_pulses", irq_rises - rises0, 1);
      check("irq_width", irq_hi - hi0, 1);
      check("irq_after_second", irq_last_cyc >= e1 + 1 + 2 * FRAME, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
